// File: rtl/sum_lane_serializer.sv
// -----------------------------------------------------------------------------
// sum_lane_serializer
//
// Captures one frame of CNT lane sums from the multi-lane adder in a single
// valid/ready transfer, then replays the frame one lane per beat on a
// valid/ready output stream. Each beat carries the lane sum, its lane index,
// the adder carry-out (top bit of the sum) and a last flag. The last beat also
// carries the total of every lane sum in the frame.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - a frame of CNT lane sums is available
//   in_ready   - block can accept a frame (only while idle and out of reset)
//   in_sum     - flattened lane sums, lane i at [i*(N+1) +: N+1]
//   out_valid  - a beat is available
//   out_ready  - consumer accepts the current beat
//   out_data   - lane sum of the current beat
//   out_lane   - lane index of out_data
//   out_carry  - adder carry-out, equal to out_data[N]
//   out_last   - current beat is lane CNT-1
//   out_total  - frame total, non-zero only on the last beat
//
// All out_* are decoded from registers only, so in_sum may come straight from
// combinational adder logic without creating a through path.
// -----------------------------------------------------------------------------
module sum_lane_serializer #(
    parameter  int N   = 12,
    parameter  int CNT = 8,
    localparam int LW  = (CNT > 1) ? $clog2(CNT) : 1,
    localparam int TW  = N + 1 + $clog2(CNT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CNT*(N+1)-1:0]   in_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N:0]             out_data,
    output logic [LW-1:0]          out_lane,
    output logic                   out_carry,
    output logic                   out_last,
    output logic [TW-1:0]          out_total
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT*(N+1)-1:0]    hold_r;
    logic [LW-1:0]           idx_r;
    logic [TW-1:0]           acc_r;

    logic                    busy_s;
    logic                    last_s;
    logic                    in_fire_s;
    logic                    out_fire_s;
    logic [N:0]              lane_data_s;
    logic [TW-1:0]           total_s;

    assign busy_s     = (state_r == BUSY);
    assign last_s     = (idx_r == LW'(CNT - 1));
    assign in_ready   = rst_n & (state_r == IDLE);
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = busy_s & out_ready;

    // Select the held lane addressed by idx_r (AND-OR mux, no variable slicing)
    always_comb begin
        lane_data_s = {(N+1){1'b0}};
        for (int i = 0; i < CNT; i++) begin
            lane_data_s = lane_data_s |
                          (hold_r[i*(N+1) +: (N+1)] & {(N+1){idx_r == LW'(i)}});
        end
    end

    // Running total including the beat currently on the output
    assign total_s = acc_r + TW'(lane_data_s);

    // Output decode: everything is forced to zero while idle
    assign out_valid = busy_s;
    assign out_data  = busy_s ? lane_data_s : {(N+1){1'b0}};
    assign out_lane  = busy_s ? idx_r : {LW{1'b0}};
    assign out_carry = out_data[N];
    assign out_last  = busy_s & last_s;
    assign out_total = out_last ? total_s : {TW{1'b0}};

    // Next-state decode for the IDLE/BUSY handshake controller
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_fire_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (out_fire_s && last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, frame holding register, lane index and accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            hold_r  <= {(CNT*(N+1)){1'b0}};
            idx_r   <= {LW{1'b0}};
            acc_r   <= {TW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (in_fire_s) begin
                        hold_r <= in_sum;
                        idx_r  <= {LW{1'b0}};
                        acc_r  <= {TW{1'b0}};
                    end
                end
                BUSY: begin
                    // New frames are ignored here; hold_r stays untouched
                    if (out_ready) begin
                        if (last_s) begin
                            idx_r <= {LW{1'b0}};
                            acc_r <= {TW{1'b0}};
                        end else begin
                            idx_r <= idx_r + LW'(1);
                            acc_r <= total_s;
                        end
                    end
                end
                default: begin
                    idx_r <= {LW{1'b0}};
                    acc_r <= {TW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_lane_serializer.sv
// -----------------------------------------------------------------------------
// Bench for sum_lane_serializer. The main instance uses N=12, CNT=8; a second
// instance with CNT=1 covers the single-lane build. Expected beats are pushed
// to a queue when a frame is accepted and popped when the DUT hands out a beat.
// -----------------------------------------------------------------------------
module tb_sum_lane_serializer;

    localparam int N   = 12;
    localparam int CNT = 8;
    localparam int W   = N + 1;
    localparam int FW  = CNT * W;

    typedef struct {
        logic [12:0] data;
        logic [2:0]  lane;
        logic        last;
        logic [15:0] total;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_sum;
    logic          out_valid;
    logic          out_ready;
    logic [12:0]   out_data;
    logic [2:0]    out_lane;
    logic          out_carry;
    logic          out_last;
    logic [15:0]   out_total;

    logic          in_valid1;
    logic          in_ready1;
    logic [12:0]   in_sum1;
    logic          out_valid1;
    logic          out_ready1;
    logic [12:0]   out_data1;
    logic [0:0]    out_lane1;
    logic          out_carry1;
    logic          out_last1;
    logic [12:0]   out_total1;

    int    checks;
    int    errors;
    beat_t q[$];
    beat_t exp_b;
    int    rdy_mode;
    int    rdy_cnt;

    logic        have_snap;
    logic [12:0] snap_data;
    logic [2:0]  snap_lane;
    logic [15:0] snap_total;
    logic        snap_last;

    sum_lane_serializer #(.N(N), .CNT(CNT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_carry (out_carry),
        .out_last  (out_last),
        .out_total (out_total)
    );

    sum_lane_serializer #(.N(N), .CNT(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_sum    (in_sum1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .out_lane  (out_lane1),
        .out_carry (out_carry1),
        .out_last  (out_last1),
        .out_total (out_total1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Consumer back-pressure: 0 = always ready, 1 = pattern 1,0,0, 2 = random
    initial begin
        out_ready = 1'b1;
        rdy_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            rdy_cnt++;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((rdy_cnt % 3) == 0);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: stall stability and scoreboard comparison
    always @(negedge clk) begin
        if (rst_n) begin
            if (have_snap) begin
                check_val("stall_data",  out_data,  snap_data);
                check_val("stall_lane",  out_lane,  snap_lane);
                check_val("stall_last",  out_last,  snap_last);
                check_val("stall_total", out_total, snap_total);
                check_val("stall_valid", out_valid, 1'b1);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_val("unexpected_beat", out_lane, 3'd0);
                    check_val("unexpected_beat_valid", 1'b1, 1'b0);
                end else begin
                    exp_b = q.pop_front();
                    check_val("beat_data",  out_data,  exp_b.data);
                    check_val("beat_lane",  out_lane,  exp_b.lane);
                    check_val("beat_carry", out_carry, exp_b.data[12]);
                    check_val("beat_last",  out_last,  exp_b.last);
                    check_val("beat_total", out_total, exp_b.total);
                end
            end
            if (!out_valid) begin
                check_val("idle_total", out_total, 16'd0);
                check_val("idle_data",  out_data,  13'd0);
            end
            have_snap  = out_valid && !out_ready;
            snap_data  = out_data;
            snap_lane  = out_lane;
            snap_last  = out_last;
            snap_total = out_total;
        end else begin
            have_snap = 1'b0;
        end
    end

    task automatic send_frame(input logic [FW-1:0] f);
        beat_t       b;
        logic [15:0] run;
        bit          done;
        in_sum   = f;
        in_valid = 1'b1;
        done     = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                run  = 16'd0;
                for (int i = 0; i < CNT; i++) begin
                    b.data  = f[i*W +: W];
                    b.lane  = 3'(i);
                    b.last  = (i == CNT - 1);
                    run     = run + 16'(b.data);
                    b.total = b.last ? run : 16'd0;
                    q.push_back(b);
                end
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_sum   = FW'({$urandom, $urandom, $urandom, $urandom});
                check_val("ready_drop", in_ready, 1'b0);
            end
        end
        if (!done) begin
            in_valid = 1'b0;
            check_val("accept_timeout", 1'b0, 1'b1);
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0) done = 1'b1;
        end
        check_val("drain_done", done, 1'b1);
        check_val("ready_after_last", in_ready, 1'b1);
        check_val("valid_after_last", out_valid, 1'b0);
    endtask

    initial begin
        logic [FW-1:0] f;
        bit            seen;
        checks     = 0;
        errors     = 0;
        rdy_mode   = 0;
        have_snap  = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_sum     = FW'({$urandom, $urandom, $urandom, $urandom});
        in_valid1  = 1'b0;
        in_sum1    = 13'd0;
        out_ready1 = 1'b0;

        // Reset: in_ready held low even with in_valid high
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready",  in_ready,  1'b0);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_out_data",  out_data,  13'd0);
        check_val("rst_out_lane",  out_lane,  3'd0);
        check_val("rst_out_last",  out_last,  1'b0);
        check_val("rst_out_total", out_total, 16'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check_val("rst_release_ready", in_ready, 1'b1);

        // Single-lane build
        in_sum1   = 13'h0ABC;
        in_valid1 = 1'b1;
        seen      = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (in_ready1) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        check_val("c1_valid", out_valid1, 1'b1);
        check_val("c1_last",  out_last1,  1'b1);
        check_val("c1_lane",  out_lane1,  1'b0);
        check_val("c1_data",  out_data1,  13'h0ABC);
        check_val("c1_total", out_total1, 13'h0ABC);
        check_val("c1_carry", out_carry1, 1'b0);
        check_val("c1_busy_ready", in_ready1, 1'b0);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        check_val("c1_done_valid", out_valid1, 1'b0);
        check_val("c1_done_ready", in_ready1,  1'b1);
        out_ready1 = 1'b0;

        // Lanes 100*i, total 2800
        for (int i = 0; i < CNT; i++) f[i*W +: W] = 13'(100 * i);
        send_frame(f);
        wait_drain();

        // Only lane 3 at full scale: carry on lane 3 only
        f = '0;
        f[3*W +: W] = 13'h1FFF;
        send_frame(f);
        wait_drain();

        // Stall pattern 1,0,0
        rdy_mode = 1;
        for (int i = 0; i < CNT; i++) f[i*W +: W] = 13'(100 * i + 7);
        send_frame(f);
        wait_drain();
        for (int i = 0; i < CNT; i++) f[i*W +: W] = 13'($urandom);
        send_frame(f);
        wait_drain();

        // Second frame offered while busy must wait for idle
        rdy_mode = 0;
        for (int i = 0; i < CNT; i++) f[i*W +: W] = 13'($urandom);
        send_frame(f);
        for (int i = 0; i < CNT; i++) f[i*W +: W] = 13'($urandom);
        send_frame(f);
        wait_drain();

        // All lanes full scale: total 0xFFF8
        for (int i = 0; i < CNT; i++) f[i*W +: W] = 13'h1FFF;
        send_frame(f);
        wait_drain();

        // Random back-pressure
        rdy_mode = 2;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < CNT; i++) f[i*W +: W] = 13'($urandom);
            send_frame(f);
            wait_drain();
        end

        // Reset after lane 2 is accepted
        rdy_mode = 0;
        for (int i = 0; i < CNT; i++) f[i*W +: W] = 13'(50 + i);
        send_frame(f);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_lane == 3'd2) seen = 1'b1;
        end
        check_val("lane2_seen", seen, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check_val("midrst_out_valid", out_valid, 1'b0);
        check_val("midrst_out_total", out_total, 16'd0);
        q.delete();
        rst_n = 1'b1;
        #1;
        check_val("midrst_release_ready", in_ready, 1'b1);
        for (int i = 0; i < CNT; i++) f[i*W +: W] = 13'(1000 + 3 * i);
        send_frame(f);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench exceeded time limit");
    end

endmodule

// File: doc/sum_lane_serializer.md
Name: sum_lane_serializer

Overview:
- Sits directly downstream of the multi-lane adder (CNT lanes, N-bit operands, (N+1)-bit sums).
- Captures one full set of CNT lane sums in a single valid/ready transfer.
- Emits the sums one lane per beat on a valid/ready stream, tagged with lane index, carry-out bit and last flag.
- On the last beat it also presents the total of all lane sums of that frame.

Parameters:
- N, 12, operand width of the upstream adder; each lane sum is N+1 bits.
- CNT, 8, number of lanes per frame (>=1).
- LW, max(1,clog2(CNT)), lane index width (derived, not overridden).
- TW, N+1+clog2(CNT), total width (derived).

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  frame of CNT sums available.
- in_ready  output  1  block can accept a frame.
- in_sum  input  CNT*(N+1)  flattened lane sums; lane i at bits [i*(N+1) +: N+1].
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts beat.
- out_data  output  N+1  current lane sum.
- out_lane  output  LW  lane index of out_data.
- out_carry  output  1  equals out_data[N] (adder carry-out).
- out_last  output  1  beat is lane CNT-1.
- out_total  output  TW  sum of all lanes of the frame; valid only when out_valid && out_last, 0 otherwise.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- States: IDLE, BUSY. Registers: hold (CNT*(N+1)), idx (LW), acc (TW), state.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, idx=0, acc=0, hold=0.
  - in_ready is forced to 0 combinationally while rst_n=0.
  - out_valid=0, out_data=0, out_lane=0, out_carry=0, out_last=0, out_total=0.
- in_ready = rst_n && (state==IDLE). It does not depend on out_ready (no combinational path).
- IDLE:
  - out_valid=0; all out_* are 0.
  - On in_valid && in_ready: hold<=in_sum, idx<=0, acc<=0, state<=BUSY.
- BUSY:
  - out_valid=1, out_data=hold lane idx, out_lane=idx, out_carry=out_data[N], out_last=(idx==CNT-1).
  - out_total = acc + zero-extended out_data when out_last, else 0.
  - in_valid is ignored and hold is not overwritten.
- Beat accepted (out_valid && out_ready):
  - acc<=acc+out_data; idx<=idx+1.
  - If out_last: idx<=0, acc<=0, state<=IDLE.
- Stall (out_valid && !out_ready): every output and register holds, stable until accepted.
- Latency: first beat appears the cycle after frame acceptance.
- Throughput: CNT beats, then one IDLE cycle before the next frame can be accepted. Max rate is one frame per CNT+1 cycles.
- Width: acc/out_total cannot overflow (TW bits covers CNT*(2^(N+1)-1)).
- CNT=1:
  - Every beat is last; out_lane=0 (LW=1).
  - out_total=out_data; TW=N+1.
- Reset mid-frame: frame is discarded, no further beats. in_ready=1 on the first cycle with rst_n=1.
- out_* are functions of registers only; the upstream stage may drive in_sum combinationally.

Test Plan:
- Reset, then frame lanes i=100*i (N=12, CNT=8), out_ready=1 -> in_ready drops the cycle after accept.
  - 8 beats with out_lane 0..7, out_data 0,100,..,700.
  - out_last only on lane 7, out_total=2800 there, 0 on other beats.
  - in_ready=1 the cycle after the last beat.
- Lane 3=0x1FFF, others 0 -> out_carry=1 only on lane 3; out_total=0x1FFF.
- Toggle out_ready 1,0,0,1,... -> each beat held stable while out_ready=0; no lane skipped or duplicated; total still correct.
- Assert in_valid with a different in_sum during BUSY -> ignored; the second frame is accepted only after IDLE, and its beats show the second frame's values.
- Assert rst_n=0 for one cycle after lane 2 is accepted -> out_valid=0 next cycle; in_ready=1 the cycle after rst_n=1; a new frame restarts at lane 0 with acc=0.
- All lanes 0x1FFF (CNT=8) -> out_total=0xFFF8 (16 bits, no truncation).
- CNT=1 build, in_sum=0x0ABC -> single beat, out_last=1, out_lane=0, out_total=0x0ABC.
